mpmc10_port_sched: RTL and testbench

- Schedules NCH requester ports onto the single mpmc10 memory-command path.
- Round-robin arbitration selects one port and latches its request.
- Sequences the shared controller state (IDLE -> PRESET1 -> PRESET2 -> CMD -> WAIT_DONE -> ACK) and forms the byte write mask and aligned address in PRESET1.
- Sits between the per-port request interfaces and the memory-command/write-mask logic; its state output drives the downstream mask stage.

---
 rtl/mpmc10_pkg.sv | 20 ++
 rtl/mpmc10_port_sched_if.sv | 36 +++
 rtl/mpmc10_rr_arb.sv | 38 +++
 rtl/mpmc10_port_sched.sv | 141 ++++++++++++++
 tb/tb_mpmc10_port_sched.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mpmc10_pkg.sv
// mpmc10_pkg: shared types and constants for the mpmc10 port scheduler.
//   mpmc10_state_t : sequencer state encoding, exported on the state port
//                    so the downstream write-mask stage can follow it.
//   CNT_W          : width of the WAIT_DONE timeout counter.
package mpmc10_pkg;

    localparam int CNT_W = 8;

    // Plain constants rather than an enum so that older blocks comparing
    // against raw 3-bit codes keep working.
    typedef logic [2:0] mpmc10_state_t;

    localparam mpmc10_state_t IDLE      = 3'd0;
    localparam mpmc10_state_t PRESET1   = 3'd1;
    localparam mpmc10_state_t PRESET2   = 3'd2;
    localparam mpmc10_state_t CMD       = 3'd3;
    localparam mpmc10_state_t WAIT_DONE = 3'd4;
    localparam mpmc10_state_t ACK       = 3'd5;

endpackage

// File: rtl/mpmc10_port_sched_if.sv
// mpmc10_port_sched_if: bundle between the requester ports, the scheduler
// and the memory-command path.
//   Port side  : req, we, sel, adr (in to scheduler); gnt, ack, err (out).
//   Memory side: mem_cmd_rdy, mem_done (in); mem_cmd_valid, mem_we,
//                mem_mask, mem_adr (out).
//   state      : current sequencer state, consumed by the mask stage.
// Modport slave is the scheduler's view, master the environment's view.
interface mpmc10_port_sched_if #(
    parameter int NCH = 4,
    parameter int WID = 16
);
    logic [NCH-1:0]            req;
    logic [NCH-1:0]            we;
    logic [NCH*WID-1:0]        sel;
    logic [NCH*32-1:0]         adr;
    logic [NCH-1:0]            gnt;
    logic [NCH-1:0]            ack;
    logic [NCH-1:0]            err;
    mpmc10_pkg::mpmc10_state_t state;
    logic                      mem_cmd_valid;
    logic                      mem_cmd_rdy;
    logic                      mem_we;
    logic [WID-1:0]            mem_mask;
    logic [31:0]               mem_adr;
    logic                      mem_done;

    modport slave (
        input  req, we, sel, adr, mem_cmd_rdy, mem_done,
        output gnt, ack, err, state, mem_cmd_valid, mem_we, mem_mask, mem_adr
    );

    modport master (
        output req, we, sel, adr, mem_cmd_rdy, mem_done,
        input  gnt, ack, err, state, mem_cmd_valid, mem_we, mem_mask, mem_adr
    );
endinterface

// File: rtl/mpmc10_rr_arb.sv
// mpmc10_rr_arb: combinational round-robin pick.
//   req     : per-port request vector
//   ptr     : port with highest priority this round
//   gnt_nxt : one-hot winner (all zero when no request)
//   idx     : binary index of the winner
// Scans upward from ptr, wrapping modulo NCH; first set request wins.
module mpmc10_rr_arb #(
    parameter  int NCH = 4,
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] gnt_nxt,
    output logic [IW-1:0]  idx
);
    always_comb begin
        int          j;
        logic [IW-1:0] jj;
        logic        found;
        // NOTE: every combinational output gets a default before the loop so
        // no path leaves it unassigned, which would infer a latch.
        gnt_nxt = '0;
        idx     = '0;
        found   = 1'b0;
        j       = 0;
        jj      = '0;
        for (int i = 0; i < NCH; i++) begin
            j = int'(ptr) + i;
            if (j >= NCH) j = j - NCH;
            jj = IW'(j);
            if (!found && req[jj]) begin
                found       = 1'b1;
                gnt_nxt[jj] = 1'b1;
                idx         = jj;
            end
        end
    end
endmodule

// File: rtl/mpmc10_port_sched.sv
// mpmc10_port_sched: schedules NCH requester ports onto one memory-command
// path.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : requests/grants/acks per port and the memory command side
// Sequence: IDLE (arbitrate) -> PRESET1 (latch we/mask/address) ->
// PRESET2 (settle) -> CMD (valid until rdy) -> WAIT_DONE (until done or
// timeout) -> ACK (one-cycle ack/err pulse) -> IDLE.
module mpmc10_port_sched
    import mpmc10_pkg::*;
#(
    parameter int NCH = 4,
    parameter int WID = 16,
    parameter int TO  = 255
) (
    input logic               clk,
    input logic               rst_n,
    mpmc10_port_sched_if.slave bus
);
    localparam int               IW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO - 1);
    localparam logic [31:0]      ADR_LOW = 32'(WID - 1);

    mpmc10_state_t    state_r;
    logic [NCH-1:0]   gnt_r;
    logic [IW-1:0]    gidx;
    logic [IW-1:0]    ptr;
    logic [CNT_W-1:0] cnt;
    logic [NCH-1:0]   ack_r;
    logic [NCH-1:0]   err_r;
    logic             valid_r;
    logic             we_r;
    logic [WID-1:0]   mask_r;
    logic [31:0]      adr_r;

    logic [NCH-1:0]   arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic [IW-1:0]    ptr_nxt;
    logic             we_g;
    logic [WID-1:0]   sel_g;
    logic [31:0]      adr_g;

    mpmc10_rr_arb #(.NCH(NCH)) u_arb (
        .req     (bus.req),
        .ptr     (ptr),
        .gnt_nxt (arb_gnt),
        .idx     (arb_idx)
    );

    // Fields of the granted port, selected with constant slices only.
    always_comb begin
        we_g  = 1'b0;
        sel_g = '0;
        adr_g = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gidx == IW'(i)) begin
                we_g  = bus.we[i];
                sel_g = bus.sel[i*WID +: WID];
                adr_g = bus.adr[i*32 +: 32];
            end
        end
    end

    assign ptr_nxt = (gidx == IW'(NCH - 1)) ? '0 : gidx + IW'(1);

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the latched command fields are reset too, because the
            // mask stage observes them and must see zeros after an abort.
            state_r <= IDLE;
            gnt_r   <= '0;
            gidx    <= '0;
            ptr     <= '0;
            cnt     <= '0;
            ack_r   <= '0;
            err_r   <= '0;
            valid_r <= 1'b0;
            we_r    <= 1'b0;
            mask_r  <= '0;
            adr_r   <= '0;
        end else begin
            ack_r <= '0;
            err_r <= '0;
            case (state_r)
                IDLE: begin
                    if (|bus.req) begin
                        gnt_r   <= arb_gnt;
                        gidx    <= arb_idx;
                        state_r <= PRESET1;
                    end
                end
                PRESET1: begin
                    we_r    <= we_g;
                    // Reads fetch the whole beat, so nothing is masked off.
                    mask_r  <= we_g ? ~sel_g : '0;
                    adr_r   <= adr_g & ~ADR_LOW;
                    state_r <= PRESET2;
                end
                PRESET2: begin
                    valid_r <= 1'b1;
                    state_r <= CMD;
                end
                CMD: begin
                    if (bus.mem_cmd_rdy) begin
                        valid_r <= 1'b0;
                        cnt     <= '0;
                        state_r <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    cnt <= cnt + CNT_W'(1);
                    // A done arriving on the timeout cycle still counts.
                    if (bus.mem_done) begin
                        ack_r   <= gnt_r;
                        state_r <= ACK;
                    end else if (cnt == TO_LAST) begin
                        ack_r   <= gnt_r;
                        err_r   <= gnt_r;
                        state_r <= ACK;
                    end
                end
                ACK: begin
                    gnt_r   <= '0;
                    ptr     <= ptr_nxt;
                    state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.state         = state_r;
    assign bus.gnt           = gnt_r;
    assign bus.ack           = ack_r;
    assign bus.err           = err_r;
    assign bus.mem_cmd_valid = valid_r;
    assign bus.mem_we        = we_r;
    assign bus.mem_mask      = mask_r;
    assign bus.mem_adr       = adr_r;
endmodule

// File: tb/tb_mpmc10_port_sched.sv
// tb_mpmc10_port_sched: directed-vector bench for mpmc10_port_sched
// (NCH=4, WID=16, TO=20).
module tb_mpmc10_port_sched;
    import mpmc10_pkg::*;

    localparam int NCH = 4;
    localparam int WID = 16;
    localparam int TO  = 20;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mpmc10_port_sched_if #(.NCH(NCH), .WID(WID)) bus ();

    mpmc10_port_sched #(.NCH(NCH), .WID(WID), .TO(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int max, output logic hit);
        hit = 1'b0;
        for (int i = 0; i < max && !hit; i++) begin
            step();
            if (bus.ack != '0) hit = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (bus.state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d exp %0d", bus.state, IDLE); end
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b exp 0000", bus.gnt); end
        checks++; if (bus.ack !== 4'b0000 || bus.err !== 4'b0000) begin errors++; $display("FAIL rst_ack_err: got %b/%b exp 0000/0000", bus.ack, bus.err); end
        checks++; if (bus.mem_cmd_valid !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_valid_we: got %b/%b exp 0/0", bus.mem_cmd_valid, bus.mem_we); end
        checks++; if (bus.mem_mask !== 16'h0000 || bus.mem_adr !== 32'h0) begin errors++; $display("FAIL rst_mask_adr: got %h/%h exp 0000/00000000", bus.mem_mask, bus.mem_adr); end
        rst_n = 1'b1;
    endtask

    // Port 1 write; req dropped right after grant must not stop the transaction.
    task automatic test_write();
        bus.req = 4'b0010; bus.we = 4'b0010;
        bus.sel = '0; bus.sel[1*WID +: WID] = 16'h00F0;
        bus.adr = '0; bus.adr[1*32 +: 32] = 32'h0000_1234;
        step();
        checks++; if (bus.state !== PRESET1 || bus.gnt !== 4'b0010) begin errors++; $display("FAIL wr_grant: got st=%0d gnt=%b exp st=%0d gnt=0010", bus.state, bus.gnt, PRESET1); end
        checks++; if (bus.mem_cmd_valid !== 1'b0) begin errors++; $display("FAIL wr_valid_early: got %b exp 0", bus.mem_cmd_valid); end
        bus.req = 4'b0000;
        step();
        checks++; if (bus.mem_mask !== 16'hFF0F) begin errors++; $display("FAIL wr_mask: got %h exp ff0f", bus.mem_mask); end
        checks++; if (bus.mem_adr !== 32'h0000_1230) begin errors++; $display("FAIL wr_adr: got %h exp 00001230", bus.mem_adr); end
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b exp 1", bus.mem_we); end
        step();
        checks++; if (bus.state !== CMD || bus.mem_cmd_valid !== 1'b1) begin errors++; $display("FAIL wr_cmd_valid: got st=%0d v=%b exp st=%0d v=1", bus.state, bus.mem_cmd_valid, CMD); end
        bus.mem_cmd_rdy = 1'b1;
        step();
        checks++; if (bus.state !== WAIT_DONE || bus.mem_cmd_valid !== 1'b0) begin errors++; $display("FAIL wr_wait: got st=%0d v=%b exp st=%0d v=0", bus.state, bus.mem_cmd_valid, WAIT_DONE); end
        bus.mem_cmd_rdy = 1'b0;
        bus.mem_done = 1'b1;
        step();
        checks++; if (bus.ack !== 4'b0010 || bus.err !== 4'b0000) begin errors++; $display("FAIL wr_ack: got ack=%b err=%b exp 0010/0000", bus.ack, bus.err); end
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL wr_gnt_held: got %b exp 0010", bus.gnt); end
        bus.mem_done = 1'b0;
        step();
        checks++; if (bus.state !== IDLE || bus.gnt !== 4'b0000 || bus.ack !== 4'b0000) begin errors++; $display("FAIL wr_idle: got st=%0d gnt=%b ack=%b exp %0d/0000/0000", bus.state, bus.gnt, bus.ack, IDLE); end
    endtask

    // Port 0 read; mem_done outside WAIT_DONE must be ignored.
    task automatic test_read();
        bus.req = 4'b0001; bus.we = 4'b0000;
        bus.sel = '0; bus.sel[0 +: WID] = 16'h0001;
        bus.adr = '0; bus.adr[0 +: 32] = 32'h0000_ABCD;
        bus.mem_done = 1'b1;
        step();
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL rd_grant: got %b exp 0001", bus.gnt); end
        step();
        checks++; if (bus.mem_mask !== 16'h0000 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL rd_mask_we: got %h/%b exp 0000/0", bus.mem_mask, bus.mem_we); end
        checks++; if (bus.mem_adr !== 32'h0000_ABC0) begin errors++; $display("FAIL rd_adr: got %h exp 0000abc0", bus.mem_adr); end
        step();
        step();
        checks++; if (bus.state !== CMD || bus.mem_cmd_valid !== 1'b1) begin errors++; $display("FAIL rd_stay_cmd: got st=%0d v=%b exp st=%0d v=1", bus.state, bus.mem_cmd_valid, CMD); end
        bus.mem_done = 1'b0;
        bus.mem_cmd_rdy = 1'b1;
        step();
        bus.mem_cmd_rdy = 1'b0;
        bus.mem_done = 1'b1;
        step();
        checks++; if (bus.ack !== 4'b0001 || bus.err !== 4'b0000) begin errors++; $display("FAIL rd_ack: got ack=%b err=%b exp 0001/0000", bus.ack, bus.err); end
        bus.mem_done = 1'b0;
        bus.req = 4'b0000;
        step();
    endtask

    // Ports 0,2,3 request continuously from pointer 0.
    task automatic test_fairness();
        logic [NCH-1:0] exp_order [6];
        logic           hit;
        exp_order = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        bus.req = 4'b1101; bus.we = 4'b0000;
        bus.mem_cmd_rdy = 1'b1; bus.mem_done = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_ack(12, hit);
            checks++; if (!hit) begin errors++; $display("FAIL fair_timeout[%0d]: no ack within 12 cycles", k); end
            checks++; if (bus.ack !== exp_order[k] || bus.err !== 4'b0000) begin errors++; $display("FAIL fair_order[%0d]: got ack=%b err=%b exp %b/0000", k, bus.ack, bus.err, exp_order[k]); end
        end
        bus.req = 4'b0000; bus.mem_cmd_rdy = 1'b0; bus.mem_done = 1'b0;
        step();
        checks++; if (bus.state !== IDLE || bus.gnt !== 4'b0000) begin errors++; $display("FAIL fair_idle: got st=%0d gnt=%b exp %0d/0000", bus.state, bus.gnt, IDLE); end
    endtask

    // Port 2: 10 stalled CMD cycles, then a timeout in WAIT_DONE.
    task automatic test_stall_timeout();
        bus.req = 4'b0100; bus.we = 4'b0100;
        bus.sel = '0; bus.sel[2*WID +: WID] = 16'h8001;
        bus.adr = '0; bus.adr[2*32 +: 32] = 32'hFFFF_FFFF;
        step();
        checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL to_grant: got %b exp 0100", bus.gnt); end
        step();
        checks++; if (bus.mem_mask !== 16'h7FFE || bus.mem_adr !== 32'hFFFF_FFF0) begin errors++; $display("FAIL to_mask_adr: got %h/%h exp 7ffe/fffffff0", bus.mem_mask, bus.mem_adr); end
        step();
        for (int i = 0; i < 10; i++) begin
            checks++; if (bus.state !== CMD || bus.mem_cmd_valid !== 1'b1) begin errors++; $display("FAIL to_stall[%0d]: got st=%0d v=%b exp %0d/1", i, bus.state, bus.mem_cmd_valid, CMD); end
            step();
        end
        bus.mem_cmd_rdy = 1'b1;
        step();
        bus.mem_cmd_rdy = 1'b0;
        for (int i = 0; i < TO; i++) begin
            checks++; if (bus.state !== WAIT_DONE || bus.ack !== 4'b0000) begin errors++; $display("FAIL to_wait[%0d]: got st=%0d ack=%b exp %0d/0000", i, bus.state, bus.ack, WAIT_DONE); end
            step();
        end
        checks++; if (bus.ack !== 4'b0100 || bus.err !== 4'b0100) begin errors++; $display("FAIL to_ack_err: got ack=%b err=%b exp 0100/0100", bus.ack, bus.err); end
        bus.req = 4'b0000;
        step();
        checks++; if (bus.state !== IDLE || bus.err !== 4'b0000 || bus.gnt !== 4'b0000) begin errors++; $display("FAIL to_idle: got st=%0d err=%b gnt=%b exp %0d/0000/0000", bus.state, bus.err, bus.gnt, IDLE); end
    endtask

    // Port 1: mem_done on the very cycle the counter hits TO-1.
    task automatic test_collision();
        bus.req = 4'b0010; bus.we = 4'b0000;
        step();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL col_grant: got %b exp 0010", bus.gnt); end
        step();
        step();
        bus.mem_cmd_rdy = 1'b1;
        step();
        bus.mem_cmd_rdy = 1'b0;
        for (int i = 0; i < TO - 1; i++) step();
        checks++; if (bus.state !== WAIT_DONE) begin errors++; $display("FAIL col_last_wait: got st=%0d exp %0d", bus.state, WAIT_DONE); end
        bus.mem_done = 1'b1;
        step();
        checks++; if (bus.ack !== 4'b0010 || bus.err !== 4'b0000) begin errors++; $display("FAIL col_ack_err: got ack=%b err=%b exp 0010/0000", bus.ack, bus.err); end
        bus.mem_done = 1'b0;
        bus.req = 4'b0000;
        step();
    endtask

    // Ports 1 and 3 pending; port 3 wins from pointer 2, then reset aborts it.
    task automatic test_reset_mid();
        logic hit;
        bus.req = 4'b1010; bus.we = 4'b1000;
        bus.sel = '0; bus.sel[3*WID +: WID] = 16'h0000;
        bus.adr = '0; bus.adr[3*32 +: 32] = 32'h0000_5678;
        step();
        checks++; if (bus.gnt !== 4'b1000) begin errors++; $display("FAIL rm_grant: got %b exp 1000", bus.gnt); end
        step();
        step();
        bus.mem_cmd_rdy = 1'b1;
        step();
        bus.mem_cmd_rdy = 1'b0;
        step();
        step();
        checks++; if (bus.state !== WAIT_DONE || bus.mem_mask !== 16'hFFFF) begin errors++; $display("FAIL rm_pre: got st=%0d mask=%h exp %0d/ffff", bus.state, bus.mem_mask, WAIT_DONE); end
        rst_n = 1'b0;
        #2;
        checks++; if (bus.state !== IDLE || bus.gnt !== 4'b0000) begin errors++; $display("FAIL rm_state_gnt: got st=%0d gnt=%b exp %0d/0000", bus.state, bus.gnt, IDLE); end
        checks++; if (bus.mem_cmd_valid !== 1'b0 || bus.mem_mask !== 16'h0000 || bus.mem_adr !== 32'h0) begin errors++; $display("FAIL rm_outputs: got v=%b mask=%h adr=%h exp 0/0000/00000000", bus.mem_cmd_valid, bus.mem_mask, bus.mem_adr); end
        step();
        checks++; if (bus.ack !== 4'b0000 || bus.err !== 4'b0000) begin errors++; $display("FAIL rm_no_ack: got ack=%b err=%b exp 0000/0000", bus.ack, bus.err); end
        rst_n = 1'b1;
        step();
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL rm_regrant: got %b exp 0010", bus.gnt); end
        bus.mem_cmd_rdy = 1'b1; bus.mem_done = 1'b1;
        wait_ack(8, hit);
        checks++; if (!hit || bus.ack !== 4'b0010) begin errors++; $display("FAIL rm_ack: got hit=%b ack=%b exp 1/0010", hit, bus.ack); end
        bus.req = 4'b0000; bus.mem_cmd_rdy = 1'b0; bus.mem_done = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.req = '0; bus.we = '0; bus.sel = '0; bus.adr = '0;
        bus.mem_cmd_rdy = 1'b0; bus.mem_done = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_fairness();
        test_stall_timeout();
        test_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
